// File: rtl/pu_partial_sum_accumulator.sv
// Accumulates N_TERMS unsigned partial sums into one saturating ACC_W-bit element
// and hands it off through a one-deep valid/ready output buffer.
module pu_partial_sum_accumulator #(
    parameter int IN_W    = 12,
    parameter int ACC_W   = 16,
    parameter int N_TERMS = 4,
    parameter int CNT_W   = $clog2(N_TERMS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  psum,
    input  logic             psum_valid,
    output logic             psum_ready,
    input  logic             clear,
    output logic [ACC_W-1:0] result,
    output logic             result_valid,
    output logic             result_sat,
    input  logic             result_ready,
    output logic [CNT_W-1:0] term_count
);

    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;
    logic [ACC_W-1:0] r_result;
    logic             r_result_valid;
    logic             r_result_sat;

    logic             w_last;
    logic             w_accept;
    logic [ACC_W:0]   w_sum;
    logic             w_ovf;
    logic [ACC_W-1:0] w_sum_sat;

    assign w_last    = (r_cnt == CNT_W'(N_TERMS - 1));
    assign w_sum     = {1'b0, r_acc} + {{(ACC_W + 1 - IN_W){1'b0}}, psum};
    assign w_ovf     = w_sum[ACC_W];
    assign w_sum_sat = w_ovf ? '1 : w_sum[ACC_W-1:0];

    // Only the closing term of a group needs a free output slot; earlier terms never stall.
    assign psum_ready = rst && !clear && !(w_last && r_result_valid && !result_ready);
    assign w_accept   = psum_valid && psum_ready;

    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign result_sat   = r_result_sat;
    assign term_count   = r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc          <= '0;
            r_cnt          <= '0;
            r_sat          <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_result_sat   <= 1'b0;
        end else begin
            if (clear) begin
                r_acc <= '0;
                r_cnt <= '0;
                r_sat <= 1'b0;
            end else if (w_accept) begin
                if (w_last) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                    r_sat <= 1'b0;
                end else begin
                    r_acc <= w_sum_sat;
                    r_cnt <= r_cnt + 1'b1;
                    r_sat <= r_sat | w_ovf;
                end
            end

            // A final accept reloads the buffer even if the old element drains this cycle.
            if (w_accept && w_last) begin
                r_result       <= w_sum_sat;
                r_result_sat   <= r_sat | w_ovf;
                r_result_valid <= 1'b1;
            end else if (result_ready && r_result_valid) begin
                r_result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pu_partial_sum_accumulator.sv
// Bench for pu_partial_sum_accumulator: directed scenarios plus randomized traffic checked
// against a group-sum reference model, on a 16-bit and a 13-bit accumulator instance.
module tb_pu_partial_sum_accumulator;

    localparam int NT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] psum;
    logic        psum_valid;
    logic        clear;
    logic        result_ready;

    logic        psum_ready;
    logic [15:0] result;
    logic        result_valid;
    logic        result_sat;
    logic [1:0]  term_count;

    logic        psum_ready13;
    logic [12:0] result13;
    logic        result_valid13;
    logic        result_sat13;
    logic [1:0]  term_count13;

    int nTests = 0;
    int nFail  = 0;

    always #5 clk = ~clk;

    pu_partial_sum_accumulator #(.IN_W(12), .ACC_W(16), .N_TERMS(NT)) dut (
        .clk(clk), .rst(rst), .psum(psum), .psum_valid(psum_valid), .psum_ready(psum_ready),
        .clear(clear), .result(result), .result_valid(result_valid), .result_sat(result_sat),
        .result_ready(result_ready), .term_count(term_count)
    );

    pu_partial_sum_accumulator #(.IN_W(12), .ACC_W(13), .N_TERMS(NT)) dut13 (
        .clk(clk), .rst(rst), .psum(psum), .psum_valid(psum_valid), .psum_ready(psum_ready13),
        .clear(clear), .result(result13), .result_valid(result_valid13), .result_sat(result_sat13),
        .result_ready(result_ready), .term_count(term_count13)
    );

    // Reference model: keeps the exact running total of the group and clamps only when the
    // group closes, which is equivalent to per-step saturation for unsigned terms.
    longint      mSum = 0;
    int          mCnt = 0;
    logic        mValid = 1'b0;
    logic [15:0] mRes16 = '0;
    logic [12:0] mRes13 = '0;
    logic        mSat16 = 1'b0;
    logic        mSat13 = 1'b0;

    function automatic logic expReady();
        return rst && !clear && !(mCnt == NT - 1 && mValid && !result_ready);
    endfunction

    always @(posedge clk) begin
        logic fin;
        fin = 1'b0;
        if (!rst) begin
            mSum = 0; mCnt = 0; mValid = 1'b0;
            mRes16 = '0; mRes13 = '0; mSat16 = 1'b0; mSat13 = 1'b0;
        end else begin
            if (clear) begin
                mSum = 0; mCnt = 0;
            end else if (psum_valid && expReady()) begin
                mSum += longint'(psum);
                if (mCnt == NT - 1) begin
                    mSat16 = (mSum > 65535);
                    mRes16 = mSat16 ? 16'hFFFF : 16'(mSum);
                    mSat13 = (mSum > 8191);
                    mRes13 = mSat13 ? 13'h1FFF : 13'(mSum);
                    mSum = 0; mCnt = 0; fin = 1'b1;
                end else begin
                    mCnt++;
                end
            end
            if (fin) mValid = 1'b1;
            else if (result_ready) mValid = 1'b0;
        end
    end

    task automatic setIn(input logic v, input logic [11:0] d, input logic rr, input logic clr);
        psum_valid = v; psum = d; result_ready = rr; clear = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [11:0] d, input logic rr);
        setIn(1'b1, d, rr, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        setIn(1'b1, 12'd55, 1'b1, 1'b0);
        #1;
        nTests++; if (psum_ready !== 1'b0) begin nFail++; $display("[TB] FAIL reset_ready got %0b want 0", psum_ready); end
        tick(); tick();
        nTests++; if (result_valid !== 1'b0) begin nFail++; $display("[TB] FAIL reset_valid got %0b want 0", result_valid); end
        nTests++; if (result !== 16'd0) begin nFail++; $display("[TB] FAIL reset_result got %0d want 0", result); end
        nTests++; if (term_count !== 2'd0) begin nFail++; $display("[TB] FAIL reset_count got %0d want 0", term_count); end
        nTests++; if (result_sat !== 1'b0) begin nFail++; $display("[TB] FAIL reset_sat got %0b want 0", result_sat); end
        rst = 1'b1;
        setIn(1'b0, 12'd0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_basic();
        feed(12'd100, 1'b1); feed(12'd200, 1'b1); feed(12'd300, 1'b1);
        nTests++; if (result_valid !== 1'b0) begin nFail++; $display("[TB] FAIL basic_early_valid got %0b want 0", result_valid); end
        feed(12'd400, 1'b1);
        nTests++; if (result_valid !== 1'b1) begin nFail++; $display("[TB] FAIL basic_valid got %0b want 1", result_valid); end
        nTests++; if (result !== 16'd1000) begin nFail++; $display("[TB] FAIL basic_result got %0d want 1000", result); end
        nTests++; if (result_sat !== 1'b0) begin nFail++; $display("[TB] FAIL basic_sat got %0b want 0", result_sat); end
        setIn(1'b0, 12'd0, 1'b1, 1'b0);
        tick();
        nTests++; if (result_valid !== 1'b0) begin nFail++; $display("[TB] FAIL basic_one_cycle got %0b want 0", result_valid); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) feed(12'd4095, 1'b1);
        nTests++; if (result13 !== 13'd8191) begin nFail++; $display("[TB] FAIL sat13_result got %0d want 8191", result13); end
        nTests++; if (result_sat13 !== 1'b1) begin nFail++; $display("[TB] FAIL sat13_flag got %0b want 1", result_sat13); end
        nTests++; if (result !== 16'd16380) begin nFail++; $display("[TB] FAIL sat16_result got %0d want 16380", result); end
        nTests++; if (result_sat !== 1'b0) begin nFail++; $display("[TB] FAIL sat16_flag got %0b want 0", result_sat); end
        for (int i = 0; i < 4; i++) feed(12'd1, 1'b1);
        nTests++; if (result13 !== 13'd4) begin nFail++; $display("[TB] FAIL sat13_next_result got %0d want 4", result13); end
        nTests++; if (result_sat13 !== 1'b0) begin nFail++; $display("[TB] FAIL sat13_next_flag got %0b want 0", result_sat13); end
        setIn(1'b0, 12'd0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_backpressure();
        feed(12'd100, 1'b0); feed(12'd200, 1'b0); feed(12'd300, 1'b0); feed(12'd400, 1'b0);
        nTests++; if (result !== 16'd1000 || result_valid !== 1'b1) begin nFail++; $display("[TB] FAIL bp_held got %0d/%0b want 1000/1", result, result_valid); end
        feed(12'd1, 1'b0); feed(12'd2, 1'b0); feed(12'd3, 1'b0);
        nTests++; if (term_count !== 2'd3) begin nFail++; $display("[TB] FAIL bp_count got %0d want 3", term_count); end
        setIn(1'b1, 12'd4, 1'b0, 1'b0);
        #1;
        nTests++; if (psum_ready !== 1'b0) begin nFail++; $display("[TB] FAIL bp_stall got %0b want 0", psum_ready); end
        tick();
        nTests++; if (result !== 16'd1000 || term_count !== 2'd3) begin nFail++; $display("[TB] FAIL bp_stable got %0d/%0d want 1000/3", result, term_count); end
        setIn(1'b1, 12'd4, 1'b1, 1'b0);
        #1;
        nTests++; if (psum_ready !== 1'b1) begin nFail++; $display("[TB] FAIL bp_release got %0b want 1", psum_ready); end
        tick();
        nTests++; if (result !== 16'd10 || result_valid !== 1'b1) begin nFail++; $display("[TB] FAIL bp_next got %0d/%0b want 10/1", result, result_valid); end
        setIn(1'b0, 12'd0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_clear();
        for (int i = 0; i < 4; i++) feed(12'd10, 1'b0);
        feed(12'd5, 1'b0); feed(12'd6, 1'b0);
        setIn(1'b1, 12'd7, 1'b0, 1'b1);
        #1;
        nTests++; if (psum_ready !== 1'b0) begin nFail++; $display("[TB] FAIL clear_ready got %0b want 0", psum_ready); end
        tick();
        nTests++; if (term_count !== 2'd0) begin nFail++; $display("[TB] FAIL clear_count got %0d want 0", term_count); end
        nTests++; if (result !== 16'd40 || result_valid !== 1'b1) begin nFail++; $display("[TB] FAIL clear_survive got %0d/%0b want 40/1", result, result_valid); end
        feed(12'd1, 1'b0); feed(12'd1, 1'b0); feed(12'd1, 1'b0); feed(12'd1, 1'b1);
        nTests++; if (result !== 16'd4 || result_valid !== 1'b1) begin nFail++; $display("[TB] FAIL clear_result got %0d/%0b want 4/1", result, result_valid); end
        setIn(1'b0, 12'd0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_bubbles_reset();
        feed(12'd10, 1'b1);
        setIn(1'b0, 12'd99, 1'b1, 1'b0); tick();
        feed(12'd20, 1'b1);
        setIn(1'b0, 12'd99, 1'b1, 1'b0); tick(); tick();
        feed(12'd30, 1'b1); feed(12'd40, 1'b1);
        nTests++; if (result !== 16'd100 || result_valid !== 1'b1) begin nFail++; $display("[TB] FAIL bubble_result got %0d/%0b want 100/1", result, result_valid); end
        feed(12'd50, 1'b0); feed(12'd60, 1'b0);
        rst = 1'b0;
        setIn(1'b0, 12'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        nTests++; if (result_valid !== 1'b0 || result !== 16'd0 || term_count !== 2'd0) begin nFail++; $display("[TB] FAIL midreset got %0b/%0d/%0d want 0/0/0", result_valid, result, term_count); end
        feed(12'd1, 1'b1); feed(12'd2, 1'b1); feed(12'd3, 1'b1); feed(12'd4, 1'b1);
        nTests++; if (result !== 16'd10 || result_valid !== 1'b1) begin nFail++; $display("[TB] FAIL post_reset got %0d/%0b want 10/1", result, result_valid); end
        setIn(1'b0, 12'd0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 79) != 0);
            setIn(1'($urandom_range(0, 3) != 0), 12'($urandom_range(0, 4095)),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
            #1;
            nTests++; if (psum_ready !== expReady() || psum_ready13 !== expReady()) begin nFail++; $display("[TB] FAIL rnd_ready cyc %0d got %0b/%0b want %0b", i, psum_ready, psum_ready13, expReady()); end
            tick();
            nTests++; if (result_valid !== mValid || result_valid13 !== mValid) begin nFail++; $display("[TB] FAIL rnd_valid cyc %0d got %0b/%0b want %0b", i, result_valid, result_valid13, mValid); end
            nTests++; if (result !== mRes16 || result_sat !== mSat16) begin nFail++; $display("[TB] FAIL rnd_res16 cyc %0d got %0d/%0b want %0d/%0b", i, result, result_sat, mRes16, mSat16); end
            nTests++; if (result13 !== mRes13 || result_sat13 !== mSat13) begin nFail++; $display("[TB] FAIL rnd_res13 cyc %0d got %0d/%0b want %0d/%0b", i, result13, result_sat13, mRes13, mSat13); end
            nTests++; if (term_count !== 2'(mCnt) || term_count13 !== 2'(mCnt)) begin nFail++; $display("[TB] FAIL rnd_count cyc %0d got %0d/%0d want %0d", i, term_count, term_count13, mCnt); end
        end
    endtask

    initial begin
        rst = 1'b0;
        setIn(1'b0, 12'd0, 1'b0, 1'b0);
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_clear();
        test_bubbles_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
